// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame format constants.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd synchronizer, bit-timing counter and sample-point decision for the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around each sample point instead of a single sample.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    input  logic cnt_clr,
    input  logic half_bit,
    output logic rxd_s,
    output logic sample_tick,
    output logic sample_bit
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          rxd_m;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;

    // preset high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign target      = half_bit ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
    assign sample_tick = (cnt == target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_clr || sample_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_d <= 1'b1;
        end else begin
            rxd_d <= rxd_s;
        end
    end

    // rxd_m is next cycle's rxd_s, so the vote covers mid-1/mid/mid+1 without delaying the tick
    assign sample_bit = (rxd_d & rxd_s) | (rxd_s & rxd_m) | (rxd_d & rxd_m);
`else
    assign sample_bit = rxd_s;
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive engine: 8 data bits LSB first, even parity, one stop bit.
// Optional UART_RX_MAJORITY_EN enables majority-vote sampling in uart_rx_sampler.
//
// state  | meaning
// IDLE   | line idle; waits for rxd_s high (armed) then low
// START  | checks mid start bit; a 1 is a glitch and aborts
// DATA   | shifts in 8 data bits at mid-bit
// PARITY | samples parity bit and computes parity error
// STOP   | samples stop bit, then publishes the byte one clk later
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    uart_state_t          state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_nxt;
    logic                 frame_nxt;
    logic                 stop_done;
    logic                 armed;
    logic                 rxd_s;
    logic                 sample_tick;
    logic                 sample_bit;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .cnt_clr    (state == IDLE),
        .half_bit   (state == START),
        .rxd_s      (rxd_s),
        .sample_tick(sample_tick),
        .sample_bit (sample_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_nxt <= 1'b0;
            frame_nxt  <= 1'b0;
            stop_done  <= 1'b0;
            armed      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rxd_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (sample_bit) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        shift   <= {sample_bit, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        parity_nxt <= (^shift) ^ sample_bit ^ ~PARITY_EVEN;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        rx_data    <= shift;
                        parity_err <= parity_nxt;
                        frame_err  <= frame_nxt;
                        rx_valid   <= 1'b1;
                        busy       <= 1'b0;
                        stop_done  <= 1'b0;
                        state      <= IDLE;
                        if (rxd_s) begin
                            armed <= 1'b1;
                        end
                    end else if (sample_tick) begin
                        frame_nxt <= ~sample_bit;
                        // a break (stop sampled 0) must see the line high again before re-arming
                        armed     <= sample_bit;
                        stop_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized self-checking bench for uart_rx_fsm against a frame-level timing model.
module tb_uart_rx_fsm;

    localparam int C     = 16;
    localparam int H     = C / 2;
    localparam int LAT   = 3 + H + 10 * C;
    localparam int FRAME = 11 * C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_fsm #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    ev_t  ev_q[$];
    win_t win_q[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int last_v = -1;
    int prev_v = -1;

    logic [7:0] exp_data = 8'h00;
    logic       exp_pe = 1'b0;
    logic       exp_fe = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // model: expected pulse times, held byte/flags and busy windows
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_busy;
        if (!reset) begin
            ev_q.delete();
            win_q.delete();
            exp_data = 8'h00;
            exp_pe   = 1'b0;
            exp_fe   = 1'b0;
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_parity_err", parity_err, 0);
            chk("rst_frame_err", frame_err, 0);
        end else begin
            exp_valid = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                exp_valid = 1'b1;
                exp_data  = ev_q[0].d;
                exp_pe    = ev_q[0].pe;
                exp_fe    = ev_q[0].fe;
                void'(ev_q.pop_front());
            end
            while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
            exp_busy = (win_q.size() > 0 && win_q[0].lo <= cyc);
            chk("rx_valid", rx_valid, exp_valid);
            chk("busy", busy, exp_busy);
            chk("rx_data", rx_data, exp_data);
            chk("parity_err", parity_err, exp_pe);
            chk("frame_err", frame_err, exp_fe);
            if (rx_valid) begin
                n_valid++;
                prev_v = last_v;
                last_v = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic v);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                              input int glitch_i, output int e0);
        logic [10:0] bits;
        bits = {stop_b, (^d) ^ bad_par, d, 1'b0};
        e0 = cyc + 1;
        ev_q.push_back('{e0 + LAT, d, ^{d, bits[9]}, ~stop_b});
        win_q.push_back('{e0 + 2, e0 + 2 + H + 10 * C});
        for (int i = 0; i < FRAME; i++) begin
            rxd = bits[i / C] ^ (i == glitch_i);
            tick();
        end
    endtask

    initial begin
        int         e0;
        int         nv;
        logic [7:0] d;
        logic       sb;
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        repeat (5) tick();

        send_frame(8'hA5, 1'b0, 1'b1, -1, e0);
        idle(20, 1'b1);
        chk("t1_data", rx_data, 8'hA5);
        chk("t1_perr", parity_err, 0);
        chk("t1_ferr", frame_err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_latency", last_v - e0, 171);

        send_frame(8'h01, 1'b1, 1'b1, -1, e0);
        idle(20, 1'b1);
        chk("t2_data", rx_data, 8'h01);
        chk("t2_perr", parity_err, 1);
        chk("t2_ferr", frame_err, 0);

        nv = n_valid;
        send_frame(8'hFF, 1'b0, 1'b0, -1, e0);
        idle(3 * C, 1'b0);
        chk("t3_count", n_valid - nv, 1);
        chk("t3_data", rx_data, 8'hFF);
        chk("t3_ferr", frame_err, 1);
        chk("t3_perr", parity_err, 0);
        idle(2, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, -1, e0);
        idle(20, 1'b1);
        chk("t3_next_data", rx_data, 8'h5A);
        chk("t3_next_ferr", frame_err, 0);

        nv = n_valid;
        rxd = 1'b0;
        e0 = cyc + 1;
        win_q.push_back('{e0 + 2, e0 + 1 + H});
        repeat (3) tick();
        rxd = 1'b1;
        repeat (3) tick();
        chk("t4_busy_mid", busy, 1);
        idle(30, 1'b1);
        chk("t4_busy_end", busy, 0);
        chk("t4_no_valid", n_valid, nv);

        e0 = cyc + 1;
        win_q.push_back('{e0 + 2, e0 + 100000});
        idle(C, 1'b0);
        idle(C, 1'b1);
        idle(C, 1'b0);
        idle(C, 1'b1);
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_rst_data", rx_data, 0);
        chk("t5_rst_busy", busy, 0);
        rxd   = 1'b1;
        reset = 1'b1;
        idle(5, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, -1, e0);
        idle(20, 1'b1);
        chk("t5_data", rx_data, 8'h3C);
        chk("t5_perr", parity_err, 0);
        chk("t5_ferr", frame_err, 0);

        send_frame(8'h00, 1'b0, 1'b1, -1, e0);
        send_frame(8'hFF, 1'b0, 1'b1, -1, e0);
        idle(20, 1'b1);
        chk("t6_spacing", last_v - prev_v, 176);
        chk("t6_data", rx_data, 8'hFF);

        send_frame(8'h55, 1'b0, 1'b1, 3 * C + 2, e0);
        idle(10, 1'b1);
        chk("t7_offpoint_glitch", rx_data, 8'h55);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h55, 1'b0, 1'b1, 3 * C + H, e0);
        idle(10, 1'b1);
        chk("t8_majority_glitch", rx_data, 8'h55);
`endif

        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, ($urandom_range(0, 3) == 0), sb,
                       ($urandom_range(0, 2) == 0) ? -1 : ($urandom_range(1, 9) * C + 2), e0);
            if (sb) begin
                idle($urandom_range(0, C), 1'b1);
            end else begin
                idle($urandom_range(0, 2 * C), 1'b0);
                idle($urandom_range(1, 4), 1'b1);
            end
        end
        idle(50, 1'b1);
        chk("events_drained", ev_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
